// File: rtl/spmv_csr_engine.sv
// rtl/spmv_csr_engine.sv - CSR sparse-matrix x dense-vector multiply-accumulate engine
module spmv_csr_engine #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int MAX_ROWS = 16,
  parameter int MAX_NNZ  = 256,
  parameter int N_COLS   = 16,
  parameter int SAT      = 1,
  localparam int ROW_W   = $clog2(MAX_ROWS + 1),
  localparam int PTR_W   = $clog2(MAX_NNZ + 1),
  localparam int COL_W   = $clog2(N_COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_num_rows,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ROW_W-1:0]  o_rp_addr,
  input  logic [PTR_W-1:0]  i_rp_data,
  output logic [PTR_W-1:0]  o_nz_addr,
  input  logic [DATA_W-1:0] i_nz_val,
  input  logic [COL_W-1:0]  i_nz_col,
  output logic [COL_W-1:0]  o_x_addr,
  input  logic [DATA_W-1:0] i_x_data,
  output logic              o_y_we,
  output logic [ROW_W-1:0]  o_y_addr,
  output logic [ACC_W-1:0]  o_y_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_PTR0, S_PTR1, S_ROW, S_NZ, S_X, S_MAC, S_WR, S_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                     state;
  logic [ROW_W-1:0]           num_rows;
  logic [ROW_W-1:0]           r;
  logic [PTR_W-1:0]           lo;
  logic [PTR_W-1:0]           hi;
  logic [PTR_W-1:0]           k;
  logic                       first_row;
  logic signed [DATA_W-1:0]   val;
  logic signed [ACC_W-1:0]    acc;
  logic [COL_W-1:0]           x_addr_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       ovf;
  logic signed [ACC_W-1:0]    acc_next;
  logic [PTR_W-1:0]           k_inc;

  assign prod     = val * $signed(i_x_data);
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc + prod_ext;
  // Overflow only when both addends share a sign and the sum flips it.
  assign ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign acc_next = ((SAT != 0) && ovf) ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
  assign k_inc    = k + PTR_W'(1);

  // The column index only arrives in X, so the vector address is passed straight through then.
  assign o_x_addr = (state == S_X) ? i_nz_col : x_addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      num_rows  <= '0;
      r         <= '0;
      lo        <= '0;
      hi        <= '0;
      k         <= '0;
      first_row <= 1'b0;
      val       <= '0;
      acc       <= '0;
      x_addr_q  <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rp_addr <= '0;
      o_nz_addr <= '0;
      o_y_we    <= 1'b0;
      o_y_addr  <= '0;
      o_y_data  <= '0;
    end else begin
      o_y_we <= 1'b0;
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            num_rows  <= i_num_rows;
            o_err     <= 1'b0;
            r         <= '0;
            first_row <= 1'b1;
            o_busy    <= 1'b1;
            if (i_num_rows == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= S_PTR0;
              o_rp_addr <= '0;
            end
          end
        end
        S_PTR0: begin
          o_rp_addr <= r + ROW_W'(1);
          state     <= S_PTR1;
        end
        S_PTR1: begin
          if (first_row) lo <= i_rp_data;
          first_row <= 1'b0;
          state     <= S_ROW;
        end
        S_ROW: begin
          hi  <= i_rp_data;
          acc <= '0;
          k   <= lo;
          if (i_rp_data <= lo) begin
            if (i_rp_data < lo) o_err <= 1'b1;
            state    <= S_WR;
            o_y_we   <= 1'b1;
            o_y_addr <= r;
            o_y_data <= '0;
          end else begin
            state     <= S_NZ;
            o_nz_addr <= lo;
          end
        end
        S_NZ: state <= S_X;
        S_X: begin
          val      <= $signed(i_nz_val);
          x_addr_q <= i_nz_col;
          state    <= S_MAC;
        end
        S_MAC: begin
          acc <= acc_next;
          k   <= k_inc;
          if (k_inc == hi) begin
            state    <= S_WR;
            o_y_we   <= 1'b1;
            o_y_addr <= r;
            o_y_data <= acc_next;
          end else begin
            state     <= S_NZ;
            o_nz_addr <= k_inc;
          end
        end
        S_WR: begin
          lo <= hi;
          if (r == num_rows - ROW_W'(1)) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            r         <= r + ROW_W'(1);
            o_rp_addr <= r + ROW_W'(2);
            state     <= S_PTR1;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_csr_engine.sv
// tb/tb_spmv_csr_engine.sv - randomized scoreboard bench for spmv_csr_engine (saturating and wrapping instances)
module tb_spmv_csr_engine;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam longint AMAX = (64'sd1 <<< 31) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< 31);

  typedef struct {
    int     addr;
    longint data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [4:0] num_rows = '0;

  logic busy_s, done_s, err_s, y_we_s;
  logic [4:0] rp_addr_s, y_addr_s;
  logic [8:0] nz_addr_s, rp_q_s;
  logic [3:0] x_addr_s, nzc_q_s;
  logic [DW-1:0] nzv_q_s, x_q_s;
  logic [AW-1:0] y_data_s;

  logic busy_w, done_w, err_w, y_we_w;
  logic [4:0] rp_addr_w, y_addr_w;
  logic [8:0] nz_addr_w, rp_q_w;
  logic [3:0] x_addr_w, nzc_q_w;
  logic [DW-1:0] nzv_q_w, x_q_w;
  logic [AW-1:0] y_data_w;

  logic [8:0]           rp_mem     [0:31];
  logic signed [DW-1:0] nz_val_mem [0:511];
  logic [3:0]           nz_col_mem [0:511];
  logic signed [DW-1:0] x_mem      [0:15];

  wr_t q_s[$];
  wr_t q_w[$];
  int  total = 0;
  int  bad = 0;
  int  exp_cyc;
  bit  exp_err;

  always #5 clk = ~clk;

  spmv_csr_engine #(.DATA_W(DW), .ACC_W(AW), .SAT(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_rows(num_rows),
    .o_busy(busy_s), .o_done(done_s), .o_err(err_s),
    .o_rp_addr(rp_addr_s), .i_rp_data(rp_q_s),
    .o_nz_addr(nz_addr_s), .i_nz_val(nzv_q_s), .i_nz_col(nzc_q_s),
    .o_x_addr(x_addr_s), .i_x_data(x_q_s),
    .o_y_we(y_we_s), .o_y_addr(y_addr_s), .o_y_data(y_data_s)
  );

  spmv_csr_engine #(.DATA_W(DW), .ACC_W(AW), .SAT(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_rows(num_rows),
    .o_busy(busy_w), .o_done(done_w), .o_err(err_w),
    .o_rp_addr(rp_addr_w), .i_rp_data(rp_q_w),
    .o_nz_addr(nz_addr_w), .i_nz_val(nzv_q_w), .i_nz_col(nzc_q_w),
    .o_x_addr(x_addr_w), .i_x_data(x_q_w),
    .o_y_we(y_we_w), .o_y_addr(y_addr_w), .o_y_data(y_data_w)
  );

  // 1-cycle-latency read SRAMs, one read port set per instance
  always @(posedge clk) begin
    rp_q_s  <= rp_mem[rp_addr_s];
    nzv_q_s <= nz_val_mem[nz_addr_s];
    nzc_q_s <= nz_col_mem[nz_addr_s];
    x_q_s   <= x_mem[x_addr_s];
    rp_q_w  <= rp_mem[rp_addr_w];
    nzv_q_w <= nz_val_mem[nz_addr_w];
    nzc_q_w <= nz_col_mem[nz_addr_w];
    x_q_w   <= x_mem[x_addr_w];
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint acc_step(input longint a, input longint p, input bit sat);
    longint s;
    logic [31:0] t;
    s = a + p;
    if (sat) begin
      if (s > AMAX) s = AMAX;
      else if (s < AMIN) s = AMIN;
    end else begin
      t = s[31:0];
      s = longint'($signed(t));
    end
    return s;
  endfunction

  // Reference: row r spans [ptr[r], ptr[r+1]); 3 cycles per row plus 3 per nonzero
  task automatic compute_expect(input int nr);
    int lo, hi;
    longint as, aw, p;
    wr_t w;
    exp_cyc = (nr == 0) ? 1 : 2;
    exp_err = 1'b0;
    for (int r = 0; r < nr; r++) begin
      lo = int'(rp_mem[r]);
      hi = int'(rp_mem[r+1]);
      as = 0;
      aw = 0;
      exp_cyc += 3;
      if (hi < lo) exp_err = 1'b1;
      for (int kk = lo; kk < hi; kk++) begin
        p = longint'(nz_val_mem[kk]) * longint'(x_mem[nz_col_mem[kk]]);
        as = acc_step(as, p, 1'b1);
        aw = acc_step(aw, p, 1'b0);
        exp_cyc += 3;
      end
      w.addr = r; w.data = as; q_s.push_back(w);
      w.data = aw; q_w.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (y_we_s) begin
        if (q_s.size() == 0) check("unexpected_write_sat", 1, 0);
        else begin
          e = q_s.pop_front();
          check("y_addr_sat", longint'(y_addr_s), longint'(e.addr));
          check("y_data_sat", longint'($signed(y_data_s)), e.data);
        end
      end
      if (y_we_w) begin
        if (q_w.size() == 0) check("unexpected_write_wrap", 1, 0);
        else begin
          e = q_w.pop_front();
          check("y_addr_wrap", longint'(y_addr_w), longint'(e.addr));
          check("y_data_wrap", longint'($signed(y_data_w)), e.data);
        end
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run(input int nr, input bit extra);
    int cyc;
    bit seen;
    compute_expect(nr);
    num_rows = 5'(nr);
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_after_start", longint'(busy_s), 1);
        check("err_cleared", longint'(err_s), 0);
      end
      if (extra && cyc == 3) begin
        start = 1'b1;
        num_rows = 5'($urandom_range(0, 16));
      end
      if (extra && cyc == 4) start = 1'b0;
      if (done_s) seen = 1'b1;
    end
    start = 1'b0;
    check("done_latency", longint'(cyc), longint'(exp_cyc));
    check("busy_at_done", longint'(busy_s), 1);
    check("done_wrap_sync", longint'(done_w), 1);
    check("err_sat", longint'(err_s), longint'(exp_err));
    check("err_wrap", longint'(err_w), longint'(exp_err));
    @(negedge clk);
    check("busy_after_done", longint'(busy_s), 0);
    check("done_pulse", longint'(done_s), 0);
    check("err_sticky", longint'(err_s), longint'(exp_err));
    check("writes_pending_sat", longint'(q_s.size()), 0);
    check("writes_pending_wrap", longint'(q_w.size()), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) rp_mem[i] = '0;
    for (int i = 0; i < 512; i++) begin
      nz_val_mem[i] = '0;
      nz_col_mem[i] = '0;
    end
    for (int i = 0; i < 16; i++) x_mem[i] = '0;
  endtask

  function automatic logic signed [DW-1:0] rval();
    case ($urandom_range(0, 3))
      0: return 16'sd32767;
      1: return -16'sd32768;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic rand_matrix(output int nr);
    int p;
    nr = $urandom_range(1, 16);
    p = $urandom_range(0, 20);
    rp_mem[0] = 9'(p);
    for (int r = 0; r < nr; r++) begin
      if ($urandom_range(0, 9) == 0 && p > 0) p = p - $urandom_range(1, (p < 3) ? p : 3);
      else p = p + $urandom_range(0, 6);
      rp_mem[r+1] = 9'(p);
    end
    for (int i = 0; i < 512; i++) begin
      nz_val_mem[i] = rval();
      nz_col_mem[i] = 4'($urandom);
    end
    for (int i = 0; i < 16; i++) x_mem[i] = rval();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sat"}, longint'({busy_s, done_s, err_s, y_we_s, rp_addr_s, nz_addr_s,
                                   x_addr_s, y_addr_s, y_data_s}), 0);
    check({tag, "_wrap"}, longint'({busy_w, done_w, err_w, y_we_w, rp_addr_w, nz_addr_w,
                                    x_addr_w, y_addr_w, y_data_w}), 0);
  endtask

  initial begin
    int nr;
    int cnt;
    bit seen;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // identity 4x4
    for (int i = 0; i < 5; i++) rp_mem[i] = 9'(i);
    for (int i = 0; i < 4; i++) begin
      nz_val_mem[i] = 16'sd1;
      nz_col_mem[i] = 4'(i);
      x_mem[i] = 16'(i + 1);
    end
    run(4, 1'b0);

    // empty middle row
    clear_mem();
    rp_mem[0] = 9'd0; rp_mem[1] = 9'd2; rp_mem[2] = 9'd2; rp_mem[3] = 9'd3;
    nz_val_mem[0] = 16'sd2; nz_val_mem[1] = -16'sd3; nz_val_mem[2] = 16'sd5;
    nz_col_mem[0] = 4'd0;   nz_col_mem[1] = 4'd1;    nz_col_mem[2] = 4'd3;
    x_mem[0] = 16'sd10; x_mem[1] = 16'sd20; x_mem[2] = 16'sd0; x_mem[3] = 16'sd7;
    run(3, 1'b0);

    // saturation vs wrap
    clear_mem();
    rp_mem[0] = 9'd0; rp_mem[1] = 9'd3;
    for (int i = 0; i < 3; i++) nz_val_mem[i] = 16'sd32767;
    x_mem[0] = 16'sd32767;
    run(1, 1'b0);

    // malformed pointer, then a zero-row start back to back clears err
    clear_mem();
    rp_mem[0] = 9'd0; rp_mem[1] = 9'd3; rp_mem[2] = 9'd1;
    for (int i = 0; i < 3; i++) begin
      nz_val_mem[i] = 16'(i + 1);
      nz_col_mem[i] = 4'(i);
      x_mem[i] = 16'sd1;
    end
    run(2, 1'b0);
    run(0, 1'b0);

    // reset during a MAC of row 2
    clear_mem();
    for (int i = 0; i < 5; i++) rp_mem[i] = 9'(2 * i);
    for (int i = 0; i < 8; i++) begin
      nz_val_mem[i] = rval();
      nz_col_mem[i] = 4'($urandom);
    end
    for (int i = 0; i < 16; i++) x_mem[i] = rval();
    compute_expect(4);
    num_rows = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (y_we_s && y_addr_s == 5'd1) seen = 1'b1;
    end
    check("row1_write_seen", longint'(seen), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_run_reset");
    rst = 1'b0;
    q_s.delete();
    q_w.delete();
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(y_we_s) + int'(y_we_w);
    end
    check("no_write_after_reset", longint'(cnt), 0);
    run(4, 1'b1);

    // randomized runs, some with an ignored start while busy
    for (int t = 0; t < 40; t++) begin
      rand_matrix(nr);
      run(nr, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
